// File: rtl/regfile_scoreboard.sv
// Integer register file: two bypassed combinational reads, one write, a per-register busy
// scoreboard for RAW hazards, and a post-reset preload sweep.
module regfile_scoreboard #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned NREGS     = 32,
  parameter int unsigned AW        = $clog2(NREGS),
  parameter int unsigned INIT_MODE = 1
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [AW-1:0]   rs1,
  input  logic [AW-1:0]   rs2,
  output logic [XLEN-1:0] reg_read_rs1,
  output logic [XLEN-1:0] reg_read_rs2,
  input  logic [AW-1:0]   rd,
  input  logic [XLEN-1:0] write_data,
  input  logic            reg_write,
  input  logic            issue_valid,
  input  logic [AW-1:0]   issue_rd,
  output logic            busy_rs1,
  output logic            busy_rs2,
  output logic            ready
);

  typedef enum logic [0:0] {StInit, StRun} state_e;

  localparam logic [AW-1:0] LastIdx = AW'(NREGS - 1);

  state_e            state_q, state_d;
  logic [AW-1:0]     idx_q, idx_d;
  logic [NREGS-1:0]  busy_q, busy_d;
  logic [XLEN-1:0]   regs_q [NREGS];

  logic              wr_en;
  logic [AW-1:0]     wr_idx;
  logic [XLEN-1:0]   wr_val;

  function automatic logic valid_idx(input logic [AW-1:0] i);
    return (i != '0) && (32'(i) < NREGS);
  endfunction

  // reset is folded in combinationally so outputs drop in the same cycle reset goes low
  assign ready = reset && (state_q == StRun);

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    unique case (state_q)
      StInit: begin
        idx_d = idx_q + AW'(1);
        if (idx_q == LastIdx) state_d = StRun;
      end
      StRun: ;
      default: state_d = StInit;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StInit;
      idx_q   <= AW'(1);
      busy_q  <= '0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      busy_q  <= busy_d;
    end
  end

  // Set is applied after clear: a younger producer wins over the retiring one.
  always_comb begin
    busy_d = busy_q;
    if (ready) begin
      if (reg_write && valid_idx(rd)) busy_d[rd] = 1'b0;
      if (issue_valid && valid_idx(issue_rd)) busy_d[issue_rd] = 1'b1;
    end
  end

  always_comb begin
    wr_en  = 1'b0;
    wr_idx = rd;
    wr_val = write_data;
    if (state_q == StInit) begin
      wr_en  = reset;
      wr_idx = idx_q;
      wr_val = (INIT_MODE == 1) ? XLEN'(idx_q) : '0;
    end else if (ready && reg_write && valid_idx(rd)) begin
      wr_en = 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) regs_q[wr_idx] <= wr_val;
  end

  always_comb begin
    reg_read_rs1 = '0;
    reg_read_rs2 = '0;
    busy_rs1     = 1'b0;
    busy_rs2     = 1'b0;
    if (ready && valid_idx(rs1)) begin
      reg_read_rs1 = (reg_write && rd == rs1) ? write_data : regs_q[rs1];
      busy_rs1     = busy_q[rs1] && !(reg_write && rd == rs1);
    end
    if (ready && valid_idx(rs2)) begin
      reg_read_rs2 = (reg_write && rd == rs2) ? write_data : regs_q[rs2];
      busy_rs2     = busy_q[rs2] && !(reg_write && rd == rs2);
    end
  end

endmodule

// File: tb/tb_regfile_scoreboard.sv
// Directed self-checking bench for regfile_scoreboard with default parameters.
module tb_regfile_scoreboard;

  logic        clk = 1'b0;
  logic        reset;
  logic [4:0]  rs1, rs2, rd, issue_rd;
  logic [31:0] reg_read_rs1, reg_read_rs2, write_data;
  logic        reg_write, issue_valid;
  logic        busy_rs1, busy_rs2, ready;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  regfile_scoreboard dut (
    .clk          (clk),
    .reset        (reset),
    .rs1          (rs1),
    .rs2          (rs2),
    .reg_read_rs1 (reg_read_rs1),
    .reg_read_rs2 (reg_read_rs2),
    .rd           (rd),
    .write_data   (write_data),
    .reg_write    (reg_write),
    .issue_valid  (issue_valid),
    .issue_rd     (issue_rd),
    .busy_rs1     (busy_rs1),
    .busy_rs2     (busy_rs2),
    .ready        (ready)
  );

  // Inputs change 1 ns after the edge; checks happen 1 ns later, well clear of the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    reg_write   = 1'b0;
    issue_valid = 1'b0;
    rd          = '0;
    issue_rd    = '0;
    write_data  = '0;
  endtask

  // Counts edges from the first one sampling reset high until ready rises.
  task automatic wait_ready(input string name);
    int n = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (ready) begin
        n = i;
        break;
      end
    end
    idle();
    #1;
    total++;
    if (n !== 31) begin
      bad++;
      $display("FAIL %s: ready after %0d edges, want 31", name, n);
    end
  endtask

  task automatic test_reset();
    idle();
    reset = 1'b0;
    rs1   = 5'd10;
    rs2   = 5'd31;
    repeat (3) tick();
    #1;
    total++;
    if ({ready, busy_rs1, busy_rs2} !== 3'b000 || reg_read_rs1 !== 0 || reg_read_rs2 !== 0) begin
      bad++;
      $display("FAIL reset_outputs: ready=%b busy=%b%b rd1=%h rd2=%h, want all 0",
               ready, busy_rs1, busy_rs2, reg_read_rs1, reg_read_rs2);
    end
    reset = 1'b1;
    tick();
    #1;
    total++;
    if (ready !== 1'b0 || reg_read_rs1 !== 0) begin
      bad++;
      $display("FAIL init_masked: ready=%b rd1=%h, want 0 0", ready, reg_read_rs1);
    end
    // one edge already consumed above; 30 more expected
    begin
      int n = 1;
      for (int i = 0; i < 40 && !ready; i++) begin
        tick();
        n++;
      end
      total++;
      if (n !== 31) begin
        bad++;
        $display("FAIL ready_latency: ready after %0d edges, want 31", n);
      end
    end
  endtask

  task automatic test_init_values();
    rs1 = 5'd10;
    rs2 = 5'd31;
    #1;
    total++;
    if (reg_read_rs1 !== 32'd10 || reg_read_rs2 !== 32'd31) begin
      bad++;
      $display("FAIL init_values: got %h %h, want 0000000a 0000001f", reg_read_rs1, reg_read_rs2);
    end
    rs1 = 5'd0;
    rs2 = 5'd1;
    #1;
    total++;
    if (reg_read_rs1 !== 32'd0 || reg_read_rs2 !== 32'd1) begin
      bad++;
      $display("FAIL read_x0_x1: got %h %h, want 0 1", reg_read_rs1, reg_read_rs2);
    end
  endtask

  task automatic test_bypass();
    reg_write  = 1'b1;
    rd         = 5'd5;
    write_data = 32'hDEADBEEF;
    rs1        = 5'd5;
    rs2        = 5'd6;
    #1;
    total++;
    if (reg_read_rs1 !== 32'hDEADBEEF || reg_read_rs2 !== 32'd6) begin
      bad++;
      $display("FAIL bypass: got %h %h, want deadbeef 00000006", reg_read_rs1, reg_read_rs2);
    end
    tick();
    idle();
    #1;
    total++;
    if (reg_read_rs1 !== 32'hDEADBEEF) begin
      bad++;
      $display("FAIL write_stored: got %h, want deadbeef", reg_read_rs1);
    end
  endtask

  task automatic test_x0();
    reg_write  = 1'b1;
    rd         = 5'd0;
    write_data = 32'hFFFFFFFF;
    rs1        = 5'd0;
    tick();
    idle();
    issue_valid = 1'b1;
    issue_rd    = 5'd0;
    tick();
    idle();
    #1;
    total++;
    if (reg_read_rs1 !== 32'd0 || busy_rs1 !== 1'b0) begin
      bad++;
      $display("FAIL x0: read=%h busy=%b, want 0 0", reg_read_rs1, busy_rs1);
    end
  endtask

  task automatic test_scoreboard();
    issue_valid = 1'b1;
    issue_rd    = 5'd7;
    rs2         = 5'd7;
    #1;
    total++;
    if (busy_rs2 !== 1'b0) begin
      bad++;
      $display("FAIL busy_before_edge: got %b, want 0", busy_rs2);
    end
    tick();
    idle();
    #1;
    total++;
    if (busy_rs2 !== 1'b1) begin
      bad++;
      $display("FAIL busy_set: got %b, want 1", busy_rs2);
    end
    reg_write  = 1'b1;
    rd         = 5'd7;
    write_data = 32'h00000077;
    #1;
    total++;
    if (busy_rs2 !== 1'b0 || reg_read_rs2 !== 32'h77) begin
      bad++;
      $display("FAIL writeback_bypass: busy=%b data=%h, want 0 00000077", busy_rs2, reg_read_rs2);
    end
    tick();
    idle();
    #1;
    total++;
    if (busy_rs2 !== 1'b0 || reg_read_rs2 !== 32'h77) begin
      bad++;
      $display("FAIL busy_cleared: busy=%b data=%h, want 0 00000077", busy_rs2, reg_read_rs2);
    end
  endtask

  task automatic test_set_clear_same();
    reg_write   = 1'b1;
    rd          = 5'd9;
    write_data  = 32'h00001234;
    issue_valid = 1'b1;
    issue_rd    = 5'd9;
    tick();
    idle();
    rs1 = 5'd9;
    #1;
    total++;
    if (busy_rs1 !== 1'b1 || reg_read_rs1 !== 32'h1234) begin
      bad++;
      $display("FAIL set_wins: busy=%b data=%h, want 1 00001234", busy_rs1, reg_read_rs1);
    end
  endtask

  task automatic test_back_to_back();
    logic [31:0] vals [3];
    logic [4:0]  regs [3];
    vals[0] = 32'hA5A5_0001; regs[0] = 5'd12;
    vals[1] = 32'h5A5A_0002; regs[1] = 5'd13;
    vals[2] = 32'h0BAD_F00D; regs[2] = 5'd31;
    for (int i = 0; i < 3; i++) begin
      reg_write  = 1'b1;
      rd         = regs[i];
      write_data = vals[i];
      tick();
    end
    idle();
    issue_valid = 1'b1;
    issue_rd    = 5'd12;
    tick();
    issue_rd = 5'd13;
    tick();
    idle();
    for (int i = 0; i < 3; i++) begin
      rs1 = regs[i];
      rs2 = regs[i];
      #1;
      total++;
      if (reg_read_rs1 !== vals[i] || reg_read_rs2 !== vals[i]) begin
        bad++;
        $display("FAIL b2b_data[%0d]: got %h %h, want %h", i, reg_read_rs1, reg_read_rs2, vals[i]);
      end
      total++;
      if (busy_rs1 !== (i < 2) || busy_rs2 !== (i < 2)) begin
        bad++;
        $display("FAIL b2b_busy[%0d]: got %b %b, want %b", i, busy_rs1, busy_rs2, i < 2);
      end
    end
  endtask

  task automatic test_reset_midrun();
    issue_valid = 1'b1;
    issue_rd    = 5'd3;
    tick();
    idle();
    rs1 = 5'd3;
    rs2 = 5'd5;
    #1;
    total++;
    if (busy_rs1 !== 1'b1) begin
      bad++;
      $display("FAIL busy_x3: got %b, want 1", busy_rs1);
    end
    reset = 1'b0;
    #1;
    total++;
    if (ready !== 1'b0 || busy_rs1 !== 1'b0 || reg_read_rs2 !== 0) begin
      bad++;
      $display("FAIL midrun_reset: ready=%b busy=%b data=%h, want 0 0 0",
               ready, busy_rs1, reg_read_rs2);
    end
    tick();
    reset = 1'b1;
    // traffic during the sweep must be ignored
    reg_write   = 1'b1;
    rd          = 5'd4;
    write_data  = 32'hAAAA_AAAA;
    issue_valid = 1'b1;
    issue_rd    = 5'd4;
    wait_ready("resweep_latency");
    rs1 = 5'd3;
    rs2 = 5'd5;
    #1;
    total++;
    if (busy_rs1 !== 1'b0 || reg_read_rs1 !== 32'd3 || reg_read_rs2 !== 32'd5) begin
      bad++;
      $display("FAIL after_resweep: busy=%b x3=%h x5=%h, want 0 3 5",
               busy_rs1, reg_read_rs1, reg_read_rs2);
    end
    rs1 = 5'd4;
    #1;
    total++;
    if (busy_rs1 !== 1'b0 || reg_read_rs1 !== 32'd4) begin
      bad++;
      $display("FAIL init_traffic_ignored: busy=%b x4=%h, want 0 4", busy_rs1, reg_read_rs1);
    end
  endtask

  initial begin
    test_reset();
    test_init_values();
    test_bypass();
    test_x0();
    test_scoreboard();
    test_set_clear_same();
    test_back_to_back();
    test_reset_midrun();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
